// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin change dispenser with per-denomination stock counters
module change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int CNT_W   = 4,
    parameter int INIT_20 = 4,
    parameter int INIT_10 = 4,
    parameter int INIT_5  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             coin_ready,
    input  logic             abort,
    input  logic             refill,
    output logic             deno_20,
    output logic             deno_10,
    output logic             deno_5,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] stock_20,
    output logic [CNT_W-1:0] stock_10,
    output logic [CNT_W-1:0] stock_5,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] INIT_20_C = CNT_W'(INIT_20);
    localparam logic [CNT_W-1:0] INIT_10_C = CNT_W'(INIT_10);
    localparam logic [CNT_W-1:0] INIT_5_C  = CNT_W'(INIT_5);
    localparam logic [AMT_W-1:0] D20       = AMT_W'(20);
    localparam logic [AMT_W-1:0] D10       = AMT_W'(10);
    localparam logic [AMT_W-1:0] D5        = AMT_W'(5);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] remaining_q, remaining_d;
    logic             short_q, short_d;
    logic             done_q, done_d;
    logic             deno_20_q, deno_20_d;
    logic             deno_10_q, deno_10_d;
    logic             deno_5_q, deno_5_d;
    logic [CNT_W-1:0] stock_20_q, stock_20_d;
    logic [CNT_W-1:0] stock_10_q, stock_10_d;
    logic [CNT_W-1:0] stock_5_q, stock_5_d;

    logic can_20, can_10, can_5;

    // A denomination is usable only if it fits the debt and a coin is in stock.
    always_comb begin
        can_20 = (remaining_q >= D20) && (stock_20_q != '0);
        can_10 = (remaining_q >= D10) && (stock_10_q != '0);
        can_5  = (remaining_q >= D5)  && (stock_5_q  != '0);
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        short_d     = short_q;
        done_d      = 1'b0;
        deno_20_d   = 1'b0;
        deno_10_d   = 1'b0;
        deno_5_d    = 1'b0;
        stock_20_d  = stock_20_q;
        stock_10_d  = stock_10_q;
        stock_5_d   = stock_5_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    remaining_d = change_amt;
                    short_d     = 1'b0;
                    state_d     = S_DISPENSE;
                end
                if (refill) begin
                    stock_20_d = INIT_20_C;
                    stock_10_d = INIT_10_C;
                    stock_5_d  = INIT_5_C;
                end
            end
            S_DISPENSE: begin
                if (abort) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    short_d = (remaining_q != '0);
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    short_d = 1'b0;
                end else if (can_20) begin
                    if (coin_ready) begin
                        deno_20_d   = 1'b1;
                        remaining_d = remaining_q - D20;
                        stock_20_d  = stock_20_q - ONE_C;
                    end
                end else if (can_10) begin
                    if (coin_ready) begin
                        deno_10_d   = 1'b1;
                        remaining_d = remaining_q - D10;
                        stock_10_d  = stock_10_q - ONE_C;
                    end
                end else if (can_5) begin
                    if (coin_ready) begin
                        deno_5_d    = 1'b1;
                        remaining_d = remaining_q - D5;
                        stock_5_d   = stock_5_q - ONE_C;
                    end
                end else begin
                    // Nothing payable: residue not a multiple of 5 or stock exhausted.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    short_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            short_q     <= 1'b0;
            done_q      <= 1'b0;
            deno_20_q   <= 1'b0;
            deno_10_q   <= 1'b0;
            deno_5_q    <= 1'b0;
            stock_20_q  <= INIT_20_C;
            stock_10_q  <= INIT_10_C;
            stock_5_q   <= INIT_5_C;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            short_q     <= short_d;
            done_q      <= done_d;
            deno_20_q   <= deno_20_d;
            deno_10_q   <= deno_10_d;
            deno_5_q    <= deno_5_d;
            stock_20_q  <= stock_20_d;
            stock_10_q  <= stock_10_d;
            stock_5_q   <= stock_5_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign deno_20   = deno_20_q;
    assign deno_10   = deno_10_q;
    assign deno_5    = deno_5_q;
    assign done      = done_q;
    assign short     = short_q;
    assign remaining = remaining_q;
    assign stock_20  = stock_20_q;
    assign stock_10  = stock_10_q;
    assign stock_5   = stock_5_q;
    assign state     = state_q;

endmodule
